// File: rtl/e_cycle_arbiter.sv
// E-clock timebase and round-robin owner of the 6800-style peripheral cycle.
// One requester is granted per E period; its DTACK_n is returned when E falls.
module e_cycle_arbiter #(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned E_PERIOD     = 10,
  parameter int unsigned E_HIGH_START = 6,
  parameter int unsigned VMA_PHASE    = 3
) (
  input  logic            C7M,
  input  logic            RESET_n,
  input  logic [NREQ-1:0] REQ_n,
  output logic            E,
  output logic            VMA_n,
  output logic [NREQ-1:0] GNT_n,
  output logic [NREQ-1:0] DTACK_n,
  output logic            BUSY,
  output logic [3:0]      PH
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  PH_LAST  = 4'(E_PERIOD - 1);
  localparam logic [3:0]  PH_EHI   = 4'(E_HIGH_START);
  localparam logic [3:0]  PH_VMA   = 4'(VMA_PHASE);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t     state_q, state_d;
  idx_t       win_q, win_d;
  idx_t       rr_q, rr_d;
  logic [3:0] ph_q, ph_d;
  logic       e_q, e_d;

  idx_t       pick_idx;
  logic       pick_vld;
  idx_t       win_inc;

  // Free-running phase counter; E is derived from the next phase so E and PH agree.
  always_comb begin
    ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 4'd1;
    e_d  = (ph_d >= PH_EHI);
  end

  // Round-robin search: first active requester at or after the rr pointer.
  always_comb begin
    idx_t cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = idx_t'((32'(rr_q) + k) % NREQ);
      if (!pick_vld && !REQ_n[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next state; a released REQ_n in ACTIVE takes precedence over cycle completion.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    win_inc = (win_q == IDX_LAST) ? '0 : win_q + idx_t'(1);
    case (state_q)
      IDLE: begin
        if (ph_q == PH_VMA && pick_vld) begin
          state_d = ACTIVE;
          win_d   = pick_idx;
        end
      end
      ACTIVE: begin
        if (REQ_n[win_q]) begin
          state_d = IDLE;
          rr_d    = win_inc;
        end else if (ph_q == PH_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (REQ_n[win_q]) begin
          state_d = IDLE;
          rr_d    = win_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, phase and E registers with asynchronous reset.
  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      ph_q    <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      ph_q    <= ph_d;
      e_q     <= e_d;
    end
  end

  // Bus outputs decoded from registered state, so reset clears them without a clock.
  always_comb begin
    E       = e_q;
    PH      = ph_q;
    BUSY    = (state_q != IDLE);
    VMA_n   = (state_q != ACTIVE);
    GNT_n   = '1;
    DTACK_n = '1;
    if (state_q != IDLE) GNT_n[win_q] = 1'b0;
    if (state_q == DONE) DTACK_n[win_q] = 1'b0;
  end

endmodule

// File: tb/tb_e_cycle_arbiter.sv
// Bench for e_cycle_arbiter: directed scenarios plus random traffic,
// checked every clock against a cycle-owner reference model.
module tb_e_cycle_arbiter;

  localparam int NREQ         = 2;
  localparam int E_PERIOD     = 10;
  localparam int E_HIGH_START = 6;
  localparam int VMA_PHASE    = 3;
  localparam int IW           = $clog2(NREQ);

  logic            C7M;
  logic            RESET_n;
  logic [NREQ-1:0] REQ_n;
  logic            E;
  logic            VMA_n;
  logic [NREQ-1:0] GNT_n;
  logic [NREQ-1:0] DTACK_n;
  logic            BUSY;
  logic [3:0]      PH;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the current E cycle and whether it has completed.
  int            m_ph;
  bit            m_busy;
  bit            m_done;
  logic [IW-1:0] m_own;
  logic [IW-1:0] m_pri;
  logic [IW-1:0] grants[$];

  e_cycle_arbiter #(
    .NREQ(NREQ),
    .E_PERIOD(E_PERIOD),
    .E_HIGH_START(E_HIGH_START),
    .VMA_PHASE(VMA_PHASE)
  ) dut (
    .C7M(C7M),
    .RESET_n(RESET_n),
    .REQ_n(REQ_n),
    .E(E),
    .VMA_n(VMA_n),
    .GNT_n(GNT_n),
    .DTACK_n(DTACK_n),
    .BUSY(BUSY),
    .PH(PH)
  );

  initial begin
    C7M = 1'b0;
    forever #5 C7M = ~C7M;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_busy = 0; m_done = 0; m_own = '0; m_pri = '0;
  endtask

  task automatic model_edge();
    logic [IW-1:0] c;
    if (!RESET_n) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (REQ_n[m_own]) begin
        m_pri  = IW'((int'(m_own) + 1) % NREQ);
        m_busy = 0;
        m_done = 0;
      end else if (!m_done && m_ph == E_PERIOD - 1) begin
        m_done = 1;
      end
    end else if (m_ph == VMA_PHASE) begin
      for (int k = 0; k < NREQ; k++) begin
        c = IW'((int'(m_pri) + k) % NREQ);
        if (!m_busy && !REQ_n[c]) begin
          m_busy = 1;
          m_own  = c;
          grants.push_back(c);
        end
      end
    end
    m_ph = (m_ph + 1) % E_PERIOD;
  endtask

  task automatic compare_all();
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    g = '1;
    d = '1;
    if (m_busy) g[m_own] = 1'b0;
    if (m_busy && m_done) d[m_own] = 1'b0;
    chk("PH", 8'(PH), 8'(m_ph));
    chk("E", 8'(E), 8'(m_ph >= E_HIGH_START));
    chk("VMA_n", 8'(VMA_n), 8'(!(m_busy && !m_done)));
    chk("GNT_n", 8'(GNT_n), 8'(g));
    chk("DTACK_n", 8'(DTACK_n), 8'(d));
    chk("BUSY", 8'(BUSY), 8'(m_busy));
  endtask

  task automatic step();
    model_edge();
    @(posedge C7M);
    #1;
    compare_all();
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < E_PERIOD && m_ph != p; i++) step();
  endtask

  initial begin
    int  cnt;
    bit  got;

    // Reset state, asserted before any clock activity
    RESET_n = 1'b0;
    REQ_n   = '1;
    model_reset();
    #12;
    compare_all();
    RESET_n = 1'b1;

    // Idle timebase: three full periods
    for (int i = 0; i < 30; i++) step();

    // Single request from requester 0 at ph=1
    wait_ph(1);
    REQ_n = 2'b10;
    wait_ph(4);
    chk("grant_r0", 8'({VMA_n, GNT_n}), 8'(3'b010));
    wait_ph(0);
    chk("dtack_r0", 8'({VMA_n, DTACK_n}), 8'(3'b110));
    wait_ph(2);
    REQ_n = 2'b11;
    step();
    chk("release_r0", 8'({GNT_n, DTACK_n}), 8'(4'b1111));

    // Contention: both requesters always asking, dropping only to end a completed cycle
    grants.delete();
    for (int i = 0; i < 80 && grants.size() < 4; i++) begin
      for (int r = 0; r < NREQ; r++)
        REQ_n[IW'(r)] = (m_busy && m_done && m_own == IW'(r));
      step();
    end
    chk("contend_cnt", 8'(grants.size() >= 4), 8'd1);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk("alternate", 8'(grants[k]), 8'((k % 2 == 0) ? 1 : 0));
    REQ_n = '1;
    for (int i = 0; i < 3 && m_busy; i++) step();

    // Late request at ph=4 waits a full period: DTACK after 16 clocks
    wait_ph(4);
    REQ_n = 2'b10;
    cnt = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      cnt++;
      if (DTACK_n[0] === 1'b0) got = 1;
    end
    chk("latency16", 8'(cnt), 8'd16);
    wait_ph(2);
    REQ_n = '1;
    step();

    // Abort: requester 1 drops its request at ph=6
    wait_ph(1);
    REQ_n = 2'b01;
    wait_ph(6);
    chk("grant_r1", 8'(GNT_n), 8'(2'b01));
    REQ_n = 2'b11;
    step();
    chk("abort", 8'({VMA_n, GNT_n, DTACK_n}), 8'(5'b11111));
    wait_ph(1);
    REQ_n = 2'b00;
    wait_ph(4);
    chk("after_abort_r0", 8'(GNT_n), 8'(2'b10));
    REQ_n = 2'b11;
    step();

    // Asynchronous reset at ph=7 during ACTIVE
    wait_ph(1);
    REQ_n = 2'b01;
    wait_ph(7);
    chk("pre_reset_busy", 8'({BUSY, VMA_n}), 8'(2'b10));
    #2;
    RESET_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst", 8'({E, VMA_n, GNT_n, DTACK_n, BUSY}), 8'(7'b0111110));
    chk("async_rst_ph", 8'(PH), 8'd0);
    REQ_n = 2'b00;
    step();
    #2;
    RESET_n = 1'b1;
    #1;
    chk("rst_release_ph", 8'(PH), 8'd0);
    wait_ph(4);
    chk("post_reset_r0", 8'(GNT_n), 8'(2'b10));
    REQ_n = 2'b11;
    step();

    // Random traffic with hold-until-DTACK or occasional abandon
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (REQ_n[IW'(r)]) begin
          if ($urandom_range(3) == 0) REQ_n[IW'(r)] = 1'b0;
        end else if (m_busy && m_done && m_own == IW'(r)) begin
          if ($urandom_range(1) == 0) REQ_n[IW'(r)] = 1'b1;
        end else if ($urandom_range(31) == 0) begin
          REQ_n[IW'(r)] = 1'b1;
        end
      end
      step();
    end
    REQ_n = '1;
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
